// File: rtl/sms_timing_ring.sv
// sms_timing_ring
//   Consumes the free-running 1 MC oscillator line and steps a one-hot ring
//   of memory-cycle timing phases T0..T(PHASES-1). Adds run/stop and
//   single-cycle stepping so the machine only halts on a cycle boundary.
//
// Parameters
//   PHASES       ring phases per memory cycle (>=3)
//   SYNC_STAGES  synchronizer flops on osc (>=1)
//
// Ports
//   clk        system clock, rising edge (>=4x oscillator frequency)
//   reset_n    synchronous active-low reset
//   osc        oscillator line, asynchronous to clk
//   run        level, 1 = advance continuously
//   step       1-clk pulse, request one memory cycle while halted
//   t          one-hot phase, bit 0 = T0
//   cycle_end  1-clk pulse on each T(PHASES-1)->T0 wrap
//   running    1 while the ring is allowed to advance
//   step_ack   1-clk pulse when a stepped cycle completes
//   ring_err   sticky one-hot violation flag
//
// Build option
//   TIMING_RING_CHECK_EN  when defined, t is checked for exactly one bit
//                         set every clk; a violation sets ring_err and
//                         forces T0/HALT. Otherwise ring_err is tied low.

module sms_timing_ring #(
  parameter int PHASES      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              osc,
  input  logic              run,
  input  logic              step,
  output logic [PHASES-1:0] t,
  output logic              cycle_end,
  output logic              running,
  output logic              step_ack,
  output logic              ring_err
);

  typedef enum logic [1:0] {HALT, RUN, DRAIN, STEP} state_t;

  localparam logic [PHASES-1:0] T0 = PHASES'(1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   adv;
  logic                   wrap;
  logic [PHASES-1:0]      t_rot;

  assign adv   = sync[SYNC_STAGES-1] & ~prev;
  assign wrap  = adv & t[PHASES-1];
  assign t_rot = {t[PHASES-2:0], t[PHASES-1]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync      <= '0;
      prev      <= 1'b0;
      state     <= HALT;
      t         <= T0;
      running   <= 1'b0;
      cycle_end <= 1'b0;
      step_ack  <= 1'b0;
    end else begin
      sync[0] <= osc;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      prev <= sync[SYNC_STAGES-1];

      // a wrap always produces cycle_end, whatever the state
      cycle_end <= wrap;
      step_ack  <= 1'b0;

      unique case (state)
        HALT: begin
          // osc edges are ignored here; ring parks on T0
          t       <= T0;
          running <= 1'b0;
          if (run) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (step) begin
            state   <= STEP;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (adv) t <= t_rot;
          if (!run) begin
            // run dropped exactly on the wrap: already on the boundary
            if (wrap) begin
              state   <= HALT;
              running <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (adv) t <= t_rot;
          if (wrap) begin
            if (run) state <= RUN;
            else begin
              state   <= HALT;
              running <= 1'b0;
            end
          end else if (run) begin
            state <= RUN;
          end
        end
        STEP: begin
          if (adv) t <= t_rot;
          if (wrap) begin
            step_ack <= 1'b1;
            if (run) state <= RUN;
            else begin
              state   <= HALT;
              running <= 1'b0;
            end
          end
        end
        default: begin
          state   <= HALT;
          t       <= T0;
          running <= 1'b0;
        end
      endcase

`ifdef TIMING_RING_CHECK_EN
      // overrides the FSM: a corrupted ring is parked on T0 and halted
      if (!$onehot(t)) begin
        t       <= T0;
        state   <= HALT;
        running <= 1'b0;
      end
`endif
    end
  end

`ifdef TIMING_RING_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset_n)          ring_err <= 1'b0;
    else if (!$onehot(t))  ring_err <= 1'b1;
  end
`else
  assign ring_err = 1'b0;
`endif

endmodule
